// File: rtl/pea_ctrl_v2.sv
// PE-array controller: sequences ic passes, output channels and output tiles
// through FLUSH/CALC phases, issues buffer read strobes, and produces per-row
// result-valid pulses through a fixed-latency valid pipeline.
module pea_ctrl_v2 #(
    parameter int COL           = 8,
    parameter int TILE_LEN      = 16,
    parameter int CHN_WIDTH     = 4,
    parameter int CHN_OFT_WIDTH = 6,
    parameter int FMS_WIDTH     = 8,
    parameter int FLUSH_LAT     = 5,
    parameter int PVLD_LAT      = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_conv,
    input  logic [CHN_WIDTH-1:0] chi,
    input  logic [CHN_WIDTH-1:0] cho,
    input  logic                 stride,
    input  logic                 ksize,
    input  logic                 group,
    input  logic [FMS_WIDTH-1:0] ifm_size,
    input  logic                 pe_ready,
    output logic                 busy,
    output logic                 ifm_read,
    output logic                 wgt_read,
    output logic [COL-1:0]       pvalid,
    output logic                 ic_done,
    output logic                 oc_done,
    output logic                 tile_done,
    output logic                 conv_done,
    output logic                 cfg_err
);

    localparam int PCW = $clog2(TILE_LEN);
    localparam int CW  = CHN_WIDTH + CHN_OFT_WIDTH;
    localparam int FCW = $clog2(FLUSH_LAT);
    localparam int XW  = FMS_WIDTH + 2;

    localparam logic [XW-1:0]  OTC_S1  = XW'(TILE_LEN);
    localparam logic [XW-1:0]  OTC_S2  = XW'(TILE_LEN / 2);
    localparam logic [XW-1:0]  OTR_S1  = XW'(COL);
    localparam logic [XW-1:0]  OTR_S2  = XW'(COL / 2);
    localparam logic [PCW-1:0] PC_LAST = PCW'(TILE_LEN - 1);
    localparam logic [FCW-1:0] FL_LAST = FCW'(FLUSH_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        CALC
    } state_t;

    state_t state, state_nxt;

    // latched layer configuration
    logic [CHN_WIDTH-1:0] chi_q, cho_q;
    logic                 stride_q, ksize_q, group_q;
    logic [FMS_WIDTH-1:0] ifm_q;

    // sequencing counters
    logic [FCW-1:0] flush_cnt;
    logic [PCW-1:0] pc_col;
    logic [CW-1:0]  ic_cnt, oc_cnt;
    logic [XW-1:0]  tc_cnt, tr_cnt;
    logic           busy_q;

    logic [COL-1:0] vpipe [PVLD_LAT];
    logic           pipe_any;

    logic           en, cfg_ok, accept, vld;
    logic [FMS_WIDTH-1:0] ofm;
    logic [XW-1:0]  ofm_x, ntc_last, ntr_last, rem_c, rem_r, col_lim, row_bits;
    logic [XW-1:0]  pc_x, col_idx;
    logic [CW-1:0]  ic_last_v, oc_last_v;
    logic           last_ic, last_oc, last_tc, last_tr, col_part, row_part;
    logic           ifm_cut, col_ok;
    logic [COL-1:0] row_mask;

    assign en     = pe_ready & rstn;
    assign cfg_ok = (chi != '0) && (cho != '0) && !(ksize && (ifm_size < FMS_WIDTH'(3)));

    // output map size from the latched kernel/stride/input size
    always_comb begin
        ofm = ifm_q;
        case ({ksize_q, stride_q})
            2'b00:   ofm = ifm_q;
            2'b01:   ofm = ((ifm_q - FMS_WIDTH'(1)) >> 1) + FMS_WIDTH'(1);
            2'b10:   ofm = ifm_q - FMS_WIDTH'(2);
            default: ofm = ((ifm_q - FMS_WIDTH'(3)) >> 1) + FMS_WIDTH'(1);
        endcase
    end

    // tile geometry, loop bounds and partial-tile qualifiers
    always_comb begin
        ofm_x    = XW'(ofm);
        ntc_last = stride_q ? ((ofm_x + OTC_S2 - XW'(1)) / OTC_S2) - XW'(1)
                            : ((ofm_x + OTC_S1 - XW'(1)) / OTC_S1) - XW'(1);
        ntr_last = stride_q ? ((ofm_x + OTR_S2 - XW'(1)) / OTR_S2) - XW'(1)
                            : ((ofm_x + OTR_S1 - XW'(1)) / OTR_S1) - XW'(1);
        rem_c    = stride_q ? (ofm_x % OTC_S2) : (ofm_x % OTC_S1);
        rem_r    = stride_q ? (ofm_x % OTR_S2) : (ofm_x % OTR_S1);
        // pc_col never exceeds TILE_LEN-1, so capping the limit at TILE_LEN is implicit
        col_lim  = (stride_q ? (rem_c << 1) : rem_c) + (ksize_q ? XW'(2) : XW'(0));
        row_bits = stride_q ? (rem_r << 1) : rem_r;

        ic_last_v = group_q ? '0 : ({chi_q, {CHN_OFT_WIDTH{1'b0}}} - CW'(1));
        oc_last_v = {cho_q, {CHN_OFT_WIDTH{1'b0}}} - CW'(1);
        last_ic   = (ic_cnt == ic_last_v);
        last_oc   = (oc_cnt == oc_last_v);
        last_tc   = (tc_cnt == ntc_last);
        last_tr   = (tr_cnt == ntr_last);
        col_part  = last_tc && (rem_c != '0);
        row_part  = last_tr && (rem_r != '0);

        pc_x    = XW'(pc_col);
        col_idx = stride_q ? (pc_x >> 1) : pc_x;
        ifm_cut = col_part && (pc_x >= col_lim);
        col_ok  = (!stride_q || pc_col[0]) && (!col_part || (col_idx < rem_c));

        for (int unsigned i = 0; i < COL; i++) begin
            row_mask[i] = !row_part || (XW'(i) < row_bits);
        end
    end

    // strobes and completion pulses, all qualified by en
    always_comb begin
        accept    = en && (state == IDLE) && start_conv && cfg_ok;
        cfg_err   = rstn && (state == IDLE) && start_conv && !cfg_ok;
        ic_done   = en && (state == CALC) && (pc_col == PC_LAST);
        oc_done   = ic_done && last_ic;
        tile_done = oc_done && last_oc;
        conv_done = tile_done && last_tc && last_tr;
        wgt_read  = accept || (ic_done && !conv_done)
                 || (en && (state == FLUSH) && (flush_cnt <= FCW'(1)));
        ifm_read  = accept || (en && (state == FLUSH))
                 || (en && (state == CALC) && !ifm_cut);
        vld       = en && (state == CALC) && col_ok;
        pipe_any  = 1'b0;
        for (int unsigned i = 0; i < PVLD_LAT; i++) begin
            pipe_any = pipe_any || (vpipe[i] != '0);
        end
        busy   = rstn && (busy_q || pipe_any);
        pvalid = en ? vpipe[PVLD_LAT-1] : '0;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = FLUSH;
            FLUSH:   if (en && (flush_cnt == FL_LAST)) state_nxt = CALC;
            CALC: begin
                if (conv_done)    state_nxt = IDLE;
                else if (ic_done) state_nxt = FLUSH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // capture the layer configuration on an accepted start
    always_ff @(posedge clk) begin
        if (!rstn) begin
            chi_q    <= '0;
            cho_q    <= '0;
            stride_q <= 1'b0;
            ksize_q  <= 1'b0;
            group_q  <= 1'b0;
            ifm_q    <= '0;
        end else if (accept) begin
            chi_q    <= chi;
            cho_q    <= cho;
            stride_q <= stride;
            ksize_q  <= ksize;
            group_q  <= group;
            ifm_q    <= ifm_size;
        end
    end

    // loop counters: ic pass innermost, then oc, tile column, tile row
    always_ff @(posedge clk) begin
        if (!rstn) begin
            flush_cnt <= '0;
            pc_col    <= '0;
            ic_cnt    <= '0;
            oc_cnt    <= '0;
            tc_cnt    <= '0;
            tr_cnt    <= '0;
            busy_q    <= 1'b0;
        end else if (en) begin
            if (accept) begin
                flush_cnt <= '0;
                pc_col    <= '0;
                ic_cnt    <= '0;
                oc_cnt    <= '0;
                tc_cnt    <= '0;
                tr_cnt    <= '0;
                busy_q    <= 1'b1;
            end
            if (state == FLUSH) begin
                flush_cnt <= (flush_cnt == FL_LAST) ? '0 : flush_cnt + FCW'(1);
            end
            if (state == CALC) begin
                // TILE_LEN is a power of two, so the increment wraps to 0 on ic_done
                pc_col <= pc_col + PCW'(1);
                if (ic_done) begin
                    ic_cnt <= last_ic ? '0 : ic_cnt + CW'(1);
                    if (last_ic) begin
                        oc_cnt <= last_oc ? '0 : oc_cnt + CW'(1);
                        if (last_oc) begin
                            tc_cnt <= last_tc ? '0 : tc_cnt + XW'(1);
                            if (last_tc) tr_cnt <= last_tr ? '0 : tr_cnt + XW'(1);
                        end
                    end
                end
                if (conv_done) busy_q <= 1'b0;
            end
        end
    end

    // valid pipeline carrying the row mask of each valid CALC cycle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < PVLD_LAT; i++) vpipe[i] <= '0;
        end else if (en) begin
            vpipe[0] <= vld ? row_mask : '0;
            for (int unsigned i = 1; i < PVLD_LAT; i++) vpipe[i] <= vpipe[i-1];
        end
    end

endmodule

// File: tb/tb_pea_ctrl_v2.sv
// Self-checking bench for pea_ctrl_v2: table of layer configurations with
// hand-derived totals, a loop-nest reference of the per-cycle output stream,
// and directed stall / reset / rejected-start sequences.
module tb_pea_ctrl_v2;

    localparam int COL = 8;
    localparam int TL  = 16;
    localparam int CHW = 4;
    localparam int OFT = 1;
    localparam int FMS = 8;
    localparam int FL  = 5;
    localparam int PL  = 3;

    logic           clk = 1'b0;
    logic           rstn, start_conv, stride, ksize, group, pe_ready;
    logic [CHW-1:0] chi, cho;
    logic [FMS-1:0] ifm_size;
    logic           busy, ifm_read, wgt_read, ic_done, oc_done, tile_done, conv_done, cfg_err;
    logic [COL-1:0] pvalid;

    always #5 clk = ~clk;

    pea_ctrl_v2 #(
        .COL(COL), .TILE_LEN(TL), .CHN_WIDTH(CHW), .CHN_OFT_WIDTH(OFT),
        .FMS_WIDTH(FMS), .FLUSH_LAT(FL), .PVLD_LAT(PL)
    ) dut (
        .clk(clk), .rstn(rstn), .start_conv(start_conv), .chi(chi), .cho(cho),
        .stride(stride), .ksize(ksize), .group(group), .ifm_size(ifm_size),
        .pe_ready(pe_ready), .busy(busy), .ifm_read(ifm_read), .wgt_read(wgt_read),
        .pvalid(pvalid), .ic_done(ic_done), .oc_done(oc_done), .tile_done(tile_done),
        .conv_done(conv_done), .cfg_err(cfg_err)
    );

    typedef struct {
        string      name;
        int         ifm;
        bit         k, s, g;
        int         chi, cho;
        bit         err;
        int         ic, oc, tile, pv, len;
        logic [7:0] lm;
    } vec_t;

    typedef struct {
        bit         ifm, wgt, icd, ocd, td, cd;
        logic [7:0] vm;
    } step_t;

    vec_t  tbl [8];
    step_t mdl [$];
    int    mdl_conv;
    int    n_chk, n_fail;

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h required %0h", nm, idx, act, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {busy, cfg_err, ifm_read, wgt_read, ic_done, oc_done, tile_done, conv_done, pvalid};
    endfunction

    task automatic drive_cfg(input int ifm, input bit k, input bit s, input bit g, input int ci, input int co);
        ifm_size = 8'(ifm);
        ksize    = k;
        stride   = s;
        group    = g;
        chi      = 4'(ci);
        cho      = 4'(co);
    endtask

    // Expected per-enabled-cycle stream, built directly from the loop nest
    task automatic build_model(input int ifm, input bit k, input bit s, input bit g, input int ci, input int co);
        int    ofm, otc, otr, ntc, ntr, rc, rr, nic, noc, lim;
        step_t st;
        mdl.delete();
        if (k) ofm = s ? ((ifm - 3) >> 1) + 1 : ifm - 2;
        else   ofm = s ? ((ifm - 1) >> 1) + 1 : ifm;
        otc = s ? TL / 2 : TL;
        otr = s ? COL / 2 : COL;
        ntc = (ofm + otc - 1) / otc;
        ntr = (ofm + otr - 1) / otr;
        rc  = ofm % otc;
        rr  = ofm % otr;
        nic = g ? 1 : ci << OFT;
        noc = co << OFT;
        lim = rc * (s ? 2 : 1) + (k ? 2 : 0);
        if (lim > TL) lim = TL;
        st = '{default: 0};
        st.ifm = 1'b1;
        st.wgt = 1'b1;
        mdl.push_back(st);
        for (int tr = 0; tr < ntr; tr++)
            for (int tc = 0; tc < ntc; tc++)
                for (int oc = 0; oc < noc; oc++)
                    for (int ic = 0; ic < nic; ic++) begin
                        bit         cp, rp;
                        logic [7:0] rmask;
                        cp    = (tc == ntc - 1) && (rc != 0);
                        rp    = (tr == ntr - 1) && (rr != 0);
                        rmask = rp ? 8'((1 << (rr * (s ? 2 : 1))) - 1) : 8'hFF;
                        for (int f = 0; f < FL; f++) begin
                            st = '{default: 0};
                            st.ifm = 1'b1;
                            st.wgt = (f < 2);
                            mdl.push_back(st);
                        end
                        for (int p = 0; p < TL; p++) begin
                            int oidx;
                            st   = '{default: 0};
                            oidx = s ? p / 2 : p;
                            st.ifm = !(cp && (p >= lim));
                            if ((!s || (p % 2 == 1)) && (!cp || (oidx < rc))) st.vm = rmask;
                            if (p == TL - 1) begin
                                st.icd = 1'b1;
                                st.ocd = (ic == nic - 1);
                                st.td  = st.ocd && (oc == noc - 1);
                                st.cd  = st.td && (tc == ntc - 1) && (tr == ntr - 1);
                                st.wgt = !st.cd;
                                if (st.cd) mdl_conv = mdl.size();
                            end
                            mdl.push_back(st);
                        end
                    end
        for (int d = 0; d < PL; d++) begin
            st = '{default: 0};
            mdl.push_back(st);
        end
    endtask

    // mode 0: pe_ready high; 1: random stalls; 2: one stall window
    task automatic run_layer(input int ifm, input bit k, input bit s, input bit g, input int ci, input int co,
                             input int mode, input int st_at, input int st_len, input bit inject,
                             output int conv_cyc, output int n_ic, output int n_oc, output int n_tile,
                             output int n_pv, output logic [7:0] lmask);
        int          kk, cyc;
        logic [15:0] exp_v;
        build_model(ifm, k, s, g, ci, co);
        kk = 0; cyc = 0; conv_cyc = -1;
        n_ic = 0; n_oc = 0; n_tile = 0; n_pv = 0; lmask = '0;
        while (kk < mdl.size() && cyc < 20000) begin
            @(negedge clk);
            start_conv = (cyc == 0) || (inject && cyc == 40);
            if (cyc == 0) drive_cfg(ifm, k, s, g, ci, co);
            else drive_cfg($urandom_range(0, 255), 1'($urandom), 1'($urandom), 1'($urandom),
                           $urandom_range(0, 15), $urandom_range(0, 15));
            case (mode)
                1:       pe_ready = (cyc == 0) || ($urandom_range(0, 3) != 0);
                2:       pe_ready = !(cyc >= st_at && cyc < st_at + st_len);
                default: pe_ready = 1'b1;
            endcase
            #3;
            if (pe_ready) begin
                exp_v = {1'b0, 1'b0, mdl[kk].ifm, mdl[kk].wgt, mdl[kk].icd, mdl[kk].ocd,
                         mdl[kk].td, mdl[kk].cd, (kk >= PL) ? mdl[kk-PL].vm : 8'h00};
                check("step_outputs", kk, outs() & 16'h7FFF, exp_v);
                if (kk >= 1 && kk <= mdl_conv) check("busy_active", kk, busy, 1);
                n_ic   += int'(ic_done);
                n_oc   += int'(oc_done);
                n_tile += int'(tile_done);
                if (pvalid != '0) begin
                    n_pv++;
                    lmask = pvalid;
                end
                if (conv_done) conv_cyc = cyc;
                kk++;
            end else begin
                check("stall_outputs", cyc, outs() & 16'h7FFF, 0);
            end
            cyc++;
        end
        check("model_steps_reached", cyc, kk, mdl.size());
        @(negedge clk);
        start_conv = 1'b0;
        pe_ready   = 1'b1;
        #3;
        check("busy_after_drain", cyc, busy, 0);
    endtask

    initial begin
        int         cc, nic, noc, nt, npv, ref_cc;
        logic [7:0] lm;
        n_chk = 0; n_fail = 0;
        rstn = 1'b0; start_conv = 1'b0; pe_ready = 1'b1;
        drive_cfg(0, 0, 0, 0, 0, 0);

        tbl[0] = '{"ofm16_full",   18, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0,  8,  4, 2, 128, 168, 8'hFF};
        tbl[1] = '{"ofm11_part",   13, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0,  8,  4, 2,  88, 168, 8'h07};
        tbl[2] = '{"stride2_ofm9", 19, 1'b1, 1'b1, 1'b0, 1, 1, 1'b0, 24, 12, 6, 108, 504, 8'h03};
        tbl[3] = '{"depthwise",     8, 1'b0, 1'b0, 1'b1, 1, 2, 1'b0,  4,  4, 1,  32,  84, 8'hFF};
        tbl[4] = '{"k1x1_ofm2",     2, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0,  4,  2, 1,   8,  84, 8'h03};
        tbl[5] = '{"err_cho0",     18, 1'b1, 1'b0, 1'b0, 1, 0, 1'b1,  0,  0, 0,   0,   0, 8'h00};
        tbl[6] = '{"err_chi0",     18, 1'b1, 1'b0, 1'b0, 0, 1, 1'b1,  0,  0, 0,   0,   0, 8'h00};
        tbl[7] = '{"err_ifm2_k3",   2, 1'b1, 1'b0, 1'b0, 1, 1, 1'b1,  0,  0, 0,   0,   0, 8'h00};

        repeat (2) @(negedge clk);
        #3 check("reset_outputs", 0, outs(), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #3 check("idle_outputs", 0, outs(), 0);

        ref_cc = 0;
        foreach (tbl[i]) begin
            if (tbl[i].err) begin
                @(negedge clk);
                drive_cfg(tbl[i].ifm, tbl[i].k, tbl[i].s, tbl[i].g, tbl[i].chi, tbl[i].cho);
                start_conv = 1'b1;
                pe_ready   = 1'b1;
                #3 check({tbl[i].name, "_cfg_err"}, i, {cfg_err, busy, wgt_read, ifm_read}, 4'b1000);
                @(negedge clk);
                start_conv = 1'b0;
                #3 check({tbl[i].name, "_after"}, i, outs(), 0);
                @(negedge clk);
                #3 check({tbl[i].name, "_idle"}, i, outs(), 0);
            end else begin
                run_layer(tbl[i].ifm, tbl[i].k, tbl[i].s, tbl[i].g, tbl[i].chi, tbl[i].cho,
                          0, 0, 0, 1'b0, cc, nic, noc, nt, npv, lm);
                if (i == 0) ref_cc = cc;
                check({tbl[i].name, "_conv_cycle"}, i, cc, tbl[i].len);
                check({tbl[i].name, "_ic_done"},   i, nic, tbl[i].ic);
                check({tbl[i].name, "_oc_done"},   i, noc, tbl[i].oc);
                check({tbl[i].name, "_tile_done"}, i, nt, tbl[i].tile);
                check({tbl[i].name, "_pvalid_n"},  i, npv, tbl[i].pv);
                check({tbl[i].name, "_last_mask"}, i, lm, tbl[i].lm);
            end
        end

        // ten-cycle stall in the middle of CALC
        run_layer(18, 1'b1, 1'b0, 1'b0, 1, 1, 2, 50, 10, 1'b0, cc, nic, noc, nt, npv, lm);
        check("stall_conv_delay", 0, cc, ref_cc + 10);
        check("stall_pvalid_n", 0, npv, 128);
        check("stall_ic_done", 0, nic, 8);

        // start_conv while busy is ignored
        run_layer(18, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0, 1'b1, cc, nic, noc, nt, npv, lm);
        check("busy_start_conv_cycle", 0, cc, 168);
        check("busy_start_tile_done", 0, nt, 2);

        // one-edge reset in the middle of CALC aborts the layer
        @(negedge clk);
        drive_cfg(18, 1'b1, 1'b0, 1'b0, 1, 1);
        start_conv = 1'b1;
        pe_ready   = 1'b1;
        @(negedge clk);
        start_conv = 1'b0;
        repeat (29) @(negedge clk);
        #3 check("pre_reset_busy", 0, busy, 1);
        rstn = 1'b0;
        #1 check("during_reset_outputs", 0, outs(), 0);
        @(negedge clk);
        rstn = 1'b1;
        #3 check("post_reset_outputs", 0, outs(), 0);
        repeat (4) begin
            @(negedge clk);
            #3 check("post_reset_idle", 0, outs(), 0);
        end
        run_layer(18, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0, 1'b0, cc, nic, noc, nt, npv, lm);
        check("fresh_start_conv_cycle", 0, cc, 168);
        check("fresh_start_pvalid_n", 0, npv, 128);

        // randomized layers with random back-pressure
        for (int r = 0; r < 8; r++) begin
            bit rk, rs, rg;
            int rifm, rci, rco;
            rk   = 1'($urandom);
            rs   = 1'($urandom);
            rg   = 1'($urandom);
            rifm = rk ? $urandom_range(3, 24) : $urandom_range(1, 24);
            rci  = $urandom_range(1, 2);
            rco  = $urandom_range(1, 2);
            run_layer(rifm, rk, rs, rg, rci, rco, 1, 0, 0, 1'b0, cc, nic, noc, nt, npv, lm);
            check("rand_conv_seen", r, (cc >= 0), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
